uart_rx_deser_param: RTL



---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_sample_tick.sv | 21 ++
 rtl/uart_rx_deser_param.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared RX definitions: deserializer states, legal parameter ranges and the
// data-length clamp used wherever a frame length is accepted.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } deser_state_t;

    localparam int unsigned DATA_WIDTH_MIN = 5;
    localparam int unsigned DATA_WIDTH_MAX = 16;
    localparam int unsigned PRESCALE_MIN   = 2;

    // 0 or anything wider than the datapath means "use the full width".
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/uart_rx_sample_tick.sv
// Sample-point detector shared by the sampler and the deserializer so both
// agree on which oversampling edge carries the bit.
module uart_rx_sample_tick
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [PRESCALE_W-1:0] edge_cnt_i,
    output logic                  tick_o
);

    logic                  legal;
    logic [PRESCALE_W-1:0] last_edge;

    assign legal     = (prescale_i >= PRESCALE_W'(PRESCALE_MIN));
    assign last_edge = prescale_i - PRESCALE_W'(1);
    assign tick_o    = en_i && legal && (edge_cnt_i == last_edge);

endmodule

// File: rtl/uart_rx_deser_param.sv
// UART RX deserializer: gathers data_len bits (LSB- or MSB-first) into a
// shadow register and publishes the whole word with a one-cycle strobe.
module uart_rx_deser_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6,
    parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK_DESERIALIZER,
    input  logic                  RST_DESERIALIZER,
    input  logic                  deser_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic                  sampled_bit,
    input  logic                  msb_first,
    input  logic [LEN_W-1:0]      data_len,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  frame_abort,
    output logic                  busy,
    output logic [LEN_W-1:0]      bit_cnt
);

    deser_state_t          state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  msb_q, msb_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  valid_q, valid_d;
    logic                  abort_q, abort_d;

    logic                  tick;
    logic [LEN_W-1:0]      len_clamped;

    // Capture-path operands: live config on the start cycle, latched otherwise.
    logic                  cap_en;
    logic [LEN_W-1:0]      cap_len;
    logic                  cap_msb;
    logic [DATA_WIDTH-1:0] cap_shadow;
    logic [LEN_W-1:0]      cap_cnt;
    logic [LEN_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shadow_n;
    logic [LEN_W-1:0]      cnt_n;

    uart_rx_sample_tick #(.PRESCALE_W(PRESCALE_W)) u_tick (
        .en_i       (deser_en),
        .prescale_i (prescale),
        .edge_cnt_i (edge_cnt),
        .tick_o     (tick)
    );

    assign len_clamped = LEN_W'(clamp_len(32'(data_len), DATA_WIDTH));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        msb_d      = msb_q;
        shadow_d   = shadow_q;
        cnt_d      = cnt_q;
        pdata_d    = pdata_q;
        valid_d    = 1'b0;
        abort_d    = 1'b0;
        cap_en     = 1'b0;
        cap_len    = len_q;
        cap_msb    = msb_q;
        cap_shadow = shadow_q;
        cap_cnt    = cnt_q;

        case (state_q)
            IDLE: begin
                if (deser_en) begin
                    state_d    = COLLECT;
                    len_d      = len_clamped;
                    msb_d      = msb_first;
                    shadow_d   = '0;
                    cnt_d      = '0;
                    cap_en     = tick;
                    cap_len    = len_clamped;
                    cap_msb    = msb_first;
                    cap_shadow = '0;
                    cap_cnt    = '0;
                end
            end
            COLLECT: begin
                if (!deser_en) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cap_en = tick;
                end
            end
            DONE: begin
                if (!deser_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        idx      = cap_msb ? (cap_len - LEN_W'(1) - cap_cnt) : cap_cnt;
        shadow_n = cap_shadow;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (idx == LEN_W'(i)) shadow_n[i] = sampled_bit;
        end
        cnt_n = cap_cnt + LEN_W'(1);

        // Shadow starts cleared and idx stays below len, so upper bits stay 0.
        if (cap_en) begin
            shadow_d = shadow_n;
            cnt_d    = cnt_n;
            if (cnt_n == cap_len) begin
                pdata_d = shadow_n;
                valid_d = 1'b1;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge CLK_DESERIALIZER or negedge RST_DESERIALIZER) begin
        if (!RST_DESERIALIZER) begin
            state_q  <= IDLE;
            len_q    <= '0;
            msb_q    <= 1'b0;
            shadow_q <= '0;
            cnt_q    <= '0;
            pdata_q  <= '0;
            valid_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            msb_q    <= msb_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            pdata_q  <= pdata_d;
            valid_q  <= valid_d;
            abort_q  <= abort_d;
        end
    end

    assign p_data      = pdata_q;
    assign data_valid  = valid_q;
    assign frame_abort = abort_q;
    assign busy        = (state_q == COLLECT);
    assign bit_cnt     = cnt_q;

endmodule
